legv8_multicycle_control: RTL
=============================

# legv8_multicycle_control

- Multi-cycle control FSM for the 64-bit LEGv8 CPU.
- Fetches an instruction over a valid/request handshake and decodes the supported subset.
- Sequences the datapath through execute, memory and writeback, issuing 4-bit ALU opcodes and consuming the ALU zero flag; it is the initiator side of the ALU interface.
- Sits between instruction/data memory handshakes and the register file, PC and ALU.

## Interface

Parameters:
- none; all encodings are fixed constants in the shared package.

Ports:
- input_clock  in  1  single system clock, rising edge.
- input_reset_n  in  1  reset; asynchronous, active-low.
- output_fetch_request  out  1  instruction fetch request.
- input_instruction_valid  in  1  input_instruction is valid this cycle.
- input_instruction  in  32  fetched instruction word.
- output_alu_opcode  out  4  ALU operation: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 pass B, 1100 nor.
- output_alu_src_b  out  1  ALU operand B select: 0 = register, 1 = sign-extended immediate.
- input_alu_zero  in  1  ALU result is zero.
- output_reg2_loc  out  1  second read register select: 0 = Rm [20:16], 1 = Rt [4:0].
- output_reg_write  out  1  register file write enable.
- output_mem_to_reg  out  1  writeback data select: 1 = memory, 0 = ALU.
- output_mem_read  out  1  data memory read request.
- output_mem_write  out  1  data memory write request.
- input_mem_ready  in  1  data memory completes the current request.
- output_pc_write  out  1  PC update strobe.
- output_pc_src  out  2  PC update source: 00 = PC+4, 01 = PC+(imm19<<2), 10 = PC+(imm26<<2).
- output_instruction_done  out  1  one-cycle retire pulse.
- output_illegal  out  1  one-cycle pulse for an unsupported encoding.

## Operation

Decoded instructions:
- R-type (bits [31:21]): ADD 0x458, SUB 0x658, AND 0x450, ORR 0x550.
- LDUR 0x7C2, STUR 0x7C0 (bits [31:21]).
- CBZ: bits [31:24] = 0xB4.
- B: bits [31:26] = 0x05.
- Anything else is illegal.

Instruction register:
- 32 bits, loaded only in FETCH on a cycle with input_instruction_valid = 1.
- Reset value 0.

States:
- FETCH: output_fetch_request = 1. Stays in FETCH while input_instruction_valid = 0; on valid, loads the instruction register and goes to DECODE.
- DECODE:
  - Legal instruction: go to EXECUTE.
  - Illegal instruction: assert output_illegal, output_pc_write (pc_src 00) and output_instruction_done, then go to FETCH.
- EXECUTE:
  - ADD/SUB/AND/ORR: opcode 0010/0110/0000/0001; src_b 0; reg2_loc 0; next WRITEBACK.
  - LDUR/STUR: opcode 0010; src_b 1; reg2_loc 1; next MEMORY.
  - CBZ: opcode 0111; src_b 0; reg2_loc 1. Asserts pc_write and done, with pc_src = 01 if input_alu_zero else 00. Next FETCH.
  - B: asserts pc_write and done with pc_src 10. Next FETCH.
- MEMORY:
  - Drives mem_read (LDUR) or mem_write (STUR), opcode 0010, src_b 1, reg2_loc 1.
  - Holds the request until a rising edge with input_mem_ready = 1.
  - LDUR then goes to WRITEBACK.
  - STUR asserts pc_write (00) and done combinationally in the cycle mem_ready = 1, then goes to FETCH.
- WRITEBACK:
  - reg_write = 1; mem_to_reg = 1 for LDUR, 0 for R-type.
  - Opcode and src_b held at their EXECUTE values.
  - pc_write (00) and done asserted; next FETCH.

Output defaults:
- All outputs not listed for a state are 0, except output_alu_opcode, which defaults to 0010.

Invariants:
- pc_write and done assert exactly once per instruction, always together.
- input_instruction_valid is ignored outside FETCH.
- input_mem_ready is ignored outside MEMORY.
- input_alu_zero is used only in CBZ EXECUTE.

## Timing

- State register and instruction register only; outputs are decoded from state and the instruction register.
  - Exceptions: CBZ pc_src depends combinationally on input_alu_zero; STUR done/pc_write depend combinationally on input_mem_ready.
- Minimum cycles per instruction with zero wait states: R-type 4, LDUR 5, STUR 4, CBZ 3, B 3, illegal 2. Each wait cycle on valid or mem_ready adds one.
- Reset:
  - Asynchronous; state goes to FETCH and the instruction register to 0.
  - Outputs immediately: fetch_request 1, alu_opcode 0010, all others 0.
- Reset asserted mid-operation abandons any pending memory request in the same cycle; mem_read and mem_write drop without waiting for a clock.
- input_instruction_valid = 1 in the first cycle after reset release is accepted.

## Structure

- Package arm_cpu_pkg:
  - ALU opcode constants.
  - Instruction opcode constants.
  - FSM state enum (FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK).
  - Instruction class enum (RTYPE, LOAD, STORE, CBZ, BRANCH, ILLEGAL).
  - pc_src constants.
- Sub-module instruction_class_decoder: combinational; instruction register in, class enum plus the R-type ALU opcode out.
- Top level: FSM and output decode.

## Test plan

- Reset release, then ADD X1,X2,X3 (0x8B030041) with valid on the first cycle:
  - cycle 3: opcode 0010, src_b 0.
  - cycle 4: reg_write 1, mem_to_reg 0, pc_write with pc_src 00, done.
  - Total 4 cycles.
- SUB 0xCB030041, AND 0x8A030041, ORR 0xAA030041 in sequence: EXECUTE opcodes 0110, 0000, 0001 respectively; one done per instruction.
- LDUR X1,[X2,#8] (0xF8408041) with mem_ready held low for 3 MEMORY cycles:
  - mem_read high for 4 cycles, src_b 1.
  - WRITEBACK: mem_to_reg 1, reg_write 1.
  - Total 8 cycles.
- CBZ X5 (0xB4000045):
  - zero = 1: pc_write with pc_src 01 in cycle 3.
  - zero = 0: pc_src 00.
  - reg2_loc 1, opcode 0111 in both cases.
- 0x00000000, then B (0x14000010):
  - illegal: illegal, pc_write (00) and done pulse in the DECODE cycle.
  - B: pc_src 10 in cycle 3 of its instruction.
- STUR (0xF8008041), reset asserted during MEMORY:
  - mem_write drops asynchronously, fetch_request rises.
  - No done pulse.
  - After release, the next instruction runs normally.

Source files
------------

// File: rtl/arm_cpu_pkg.sv
// Shared encodings for the LEGv8 multi-cycle control path.
package arm_cpu_pkg;

  localparam int unsigned INSN_W   = 32;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned PC_SRC_W = 2;
  localparam int unsigned OPC11_W  = 11;
  localparam int unsigned OPC8_W   = 8;
  localparam int unsigned OPC6_W   = 6;

  // ALU operation codes
  localparam logic [ALU_OP_W-1:0] ALU_AND    = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_OR     = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD    = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_SUB    = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_PASS_B = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_NOR    = 4'b1100;

  // Instruction opcode fields
  localparam logic [OPC11_W-1:0] OPC_ADD  = 11'h458;
  localparam logic [OPC11_W-1:0] OPC_SUB  = 11'h658;
  localparam logic [OPC11_W-1:0] OPC_AND  = 11'h450;
  localparam logic [OPC11_W-1:0] OPC_ORR  = 11'h550;
  localparam logic [OPC11_W-1:0] OPC_LDUR = 11'h7C2;
  localparam logic [OPC11_W-1:0] OPC_STUR = 11'h7C0;
  localparam logic [OPC8_W-1:0]  OPC_CBZ  = 8'hB4;
  localparam logic [OPC6_W-1:0]  OPC_B    = 6'h05;

  // PC update sources
  localparam logic [PC_SRC_W-1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [PC_SRC_W-1:0] PC_SRC_COND   = 2'b01;
  localparam logic [PC_SRC_W-1:0] PC_SRC_UNCOND = 2'b10;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEMORY,
    WRITEBACK
  } state_t;

  typedef enum logic [2:0] {
    RTYPE,
    LOAD,
    STORE,
    CBZ,
    BRANCH,
    ILLEGAL
  } insn_class_t;

endpackage

// File: rtl/instruction_class_decoder.sv
// Classifies the instruction register and picks the R-type ALU operation.
module instruction_class_decoder
  import arm_cpu_pkg::*;
(
  input  logic [INSN_W-1:0]   instruction,
  output insn_class_t         insn_class_c,
  output logic [ALU_OP_W-1:0] rtype_alu_opcode_c
);

  // Operand/immediate fields play no part in classification.
  logic unused_operand_bits;
  assign unused_operand_bits = ^instruction[20:0];

  // Opcode match; the 11-bit formats are checked before CBZ and B.
  always_comb begin
    insn_class_c       = ILLEGAL;
    rtype_alu_opcode_c = ALU_ADD;
    case (instruction[31:21])
      OPC_ADD: begin
        insn_class_c       = RTYPE;
        rtype_alu_opcode_c = ALU_ADD;
      end
      OPC_SUB: begin
        insn_class_c       = RTYPE;
        rtype_alu_opcode_c = ALU_SUB;
      end
      OPC_AND: begin
        insn_class_c       = RTYPE;
        rtype_alu_opcode_c = ALU_AND;
      end
      OPC_ORR: begin
        insn_class_c       = RTYPE;
        rtype_alu_opcode_c = ALU_OR;
      end
      OPC_LDUR: insn_class_c = LOAD;
      OPC_STUR: insn_class_c = STORE;
      default: begin
        if (instruction[31:24] == OPC_CBZ) begin
          insn_class_c = CBZ;
        end else if (instruction[31:26] == OPC_B) begin
          insn_class_c = BRANCH;
        end
      end
    endcase
  end

endmodule

// File: rtl/legv8_multicycle_control.sv
// Multi-cycle control FSM for the LEGv8 CPU: fetch, decode, execute, memory, writeback.
module legv8_multicycle_control
  import arm_cpu_pkg::*;
(
  input  logic                input_clock,
  input  logic                input_reset_n,
  output logic                output_fetch_request,
  input  logic                input_instruction_valid,
  input  logic [INSN_W-1:0]   input_instruction,
  output logic [ALU_OP_W-1:0] output_alu_opcode,
  output logic                output_alu_src_b,
  input  logic                input_alu_zero,
  output logic                output_reg2_loc,
  output logic                output_reg_write,
  output logic                output_mem_to_reg,
  output logic                output_mem_read,
  output logic                output_mem_write,
  input  logic                input_mem_ready,
  output logic                output_pc_write,
  output logic [PC_SRC_W-1:0] output_pc_src,
  output logic                output_instruction_done,
  output logic                output_illegal
);

  state_t              state;
  state_t              next_state;
  logic [INSN_W-1:0]   instr_reg;
  insn_class_t         insn_class;
  logic [ALU_OP_W-1:0] rtype_alu_opcode;

  instruction_class_decoder u_decoder (
    .instruction        (instr_reg),
    .insn_class_c       (insn_class),
    .rtype_alu_opcode_c (rtype_alu_opcode)
  );

  // State register
  always_ff @(posedge input_clock or negedge input_reset_n) begin
    if (!input_reset_n) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Instruction register, captured only on an accepted fetch
  always_ff @(posedge input_clock or negedge input_reset_n) begin
    if (!input_reset_n) begin
      instr_reg <= '0;
    end else if (state == FETCH && input_instruction_valid) begin
      instr_reg <= input_instruction;
    end
  end

  // Next-state and output decode
  always_comb begin
    next_state              = state;
    output_fetch_request    = 1'b0;
    output_alu_opcode       = ALU_ADD;
    output_alu_src_b        = 1'b0;
    output_reg2_loc         = 1'b0;
    output_reg_write        = 1'b0;
    output_mem_to_reg       = 1'b0;
    output_mem_read         = 1'b0;
    output_mem_write        = 1'b0;
    output_pc_write         = 1'b0;
    output_pc_src           = PC_SRC_SEQ;
    output_instruction_done = 1'b0;
    output_illegal          = 1'b0;

    case (state)
      FETCH: begin
        output_fetch_request = 1'b1;
        if (input_instruction_valid) begin
          next_state = DECODE;
        end
      end

      DECODE: begin
        if (insn_class == ILLEGAL) begin
          output_illegal          = 1'b1;
          output_pc_write         = 1'b1;
          output_instruction_done = 1'b1;
          next_state              = FETCH;
        end else begin
          next_state = EXECUTE;
        end
      end

      EXECUTE: begin
        case (insn_class)
          RTYPE: begin
            output_alu_opcode = rtype_alu_opcode;
            next_state        = WRITEBACK;
          end
          LOAD, STORE: begin
            output_alu_src_b = 1'b1;
            output_reg2_loc  = 1'b1;
            next_state       = MEMORY;
          end
          CBZ: begin
            output_alu_opcode       = ALU_PASS_B;
            output_reg2_loc         = 1'b1;
            output_pc_write         = 1'b1;
            output_instruction_done = 1'b1;
            output_pc_src           = input_alu_zero ? PC_SRC_COND : PC_SRC_SEQ;
            next_state              = FETCH;
          end
          BRANCH: begin
            output_pc_write         = 1'b1;
            output_instruction_done = 1'b1;
            output_pc_src           = PC_SRC_UNCOND;
            next_state              = FETCH;
          end
          default: next_state = FETCH;
        endcase
      end

      MEMORY: begin
        output_alu_src_b = 1'b1;
        output_reg2_loc  = 1'b1;
        output_mem_read  = (insn_class == LOAD);
        output_mem_write = (insn_class == STORE);
        if (insn_class != LOAD && insn_class != STORE) begin
          next_state = FETCH;
        end else if (input_mem_ready) begin
          if (insn_class == LOAD) begin
            next_state = WRITEBACK;
          end else begin
            // Store retires in the completing cycle; no writeback needed.
            output_pc_write         = 1'b1;
            output_instruction_done = 1'b1;
            next_state              = FETCH;
          end
        end
      end

      WRITEBACK: begin
        output_reg_write        = 1'b1;
        output_mem_to_reg       = (insn_class == LOAD);
        output_alu_src_b        = (insn_class == LOAD);
        output_alu_opcode       = (insn_class == RTYPE) ? rtype_alu_opcode : ALU_ADD;
        output_pc_write         = 1'b1;
        output_instruction_done = 1'b1;
        next_state              = FETCH;
      end

      default: next_state = FETCH;
    endcase
  end

endmodule
